// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: round-robin sequencer running 64-bit add/sub requests as two
// chained passes through one shared 32-bit adder.
module adder_seq_ctrl #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_sub,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_c0,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_ovf,
    output logic        rsp_id,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t      state_q, state_d;
    logic        ptr_q, ptr_d, sub_q, sub_d, id_q, id_d;
    logic        clo_q, clo_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [63:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic        gnt0, gnt1, idle, lo, hi;
    // Readys are gated by rst_n so every output reads 0 while reset is held.
    assign idle       = rst_n && state_q == IDLE;
    assign lo         = state_q == LO;
    assign hi         = state_q == HI;
    assign gnt0       = req0_valid && (!req1_valid || !ptr_q);
    assign gnt1       = req1_valid && (!req0_valid || ptr_q);
    assign req0_ready = idle && gnt0;
    assign req1_ready = idle && gnt1;
    assign add_a      = lo ? a_q[31:0] : hi ? a_q[63:32] : 32'd0;
    assign add_b      = lo ? b_q[31:0] : hi ? b_q[63:32] : 32'd0;
    assign add_c0     = lo ? sub_q : hi && clo_q;
    assign rsp_valid  = state_q == DONE;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = cout_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_id     = id_q;
    assign busy       = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        id_d    = id_q;
        sum_d   = sum_q;
        clo_d   = clo_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (req0_ready || req1_ready) begin
                a_d     = gnt1 ? req1_a : req0_a;
                sub_d   = gnt1 ? req1_sub : req0_sub;
                b_d     = (gnt1 ? req1_b : req0_b) ^ {64{sub_d}};
                id_d    = gnt1;
                ptr_d   = !gnt1;
                state_d = LO;
            end
            LO: begin
                sum_d[31:0] = add_sum;
                clo_d       = add_cout;
                state_d     = HI;
            end
            HI: begin
                sum_d[63:32] = add_sum;
                cout_d       = add_cout;
                ovf_d        = (a_q[63] == b_q[63]) && (add_sum[31] != a_q[63]);
                state_d      = DONE;
            end
            default: state_d = rsp_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= RR_INIT;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            clo_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            clo_q   <= clo_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed scenarios for adder_seq_ctrl with a behavioural
// 32-bit adder wired to the add_* ports.
module tb_adder_seq_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 0, req0_ready, req0_sub = 0;
    logic        req1_valid = 0, req1_ready, req1_sub = 0;
    logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_c0, add_cout;
    logic        rsp_valid, rsp_ready = 1, rsp_cout, rsp_ovf, rsp_id, busy;
    logic [63:0] rsp_sum;
    int          n_checks = 0, n_fail = 0;

    adder_seq_ctrl #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_ovf(rsp_ovf), .rsp_id(rsp_id), .busy(busy)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c0};
    always #5 clk = ~clk;

    // Drives one operation with rsp_ready=1 and reports what came back; lat counts
    // edges from accept to rsp_valid (-1 if never granted).
    task automatic run_op(input logic id, input logic [63:0] a, b, input logic sub,
                          output logic [63:0] sum, output logic cout, ovf, rid, c0_hi, output int lat);
        int w;
        lat = 0; sum = 'x; cout = 'x; ovf = 'x; rid = 'x; c0_hi = 'x;
        rsp_ready = 1;
        if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1; end
        else begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1; end
        #1;
        w = 0;
        while (!(id ? req1_ready : req0_ready) && w < 8) begin @(posedge clk); #1; w++; end
        if (w == 8) begin
            req0_valid = 0; req1_valid = 0; lat = -1;
        end else begin
            @(posedge clk); #1;
            req0_valid = 0; req1_valid = 0; lat = 1;
            while (!rsp_valid && lat < 8) begin
                @(posedge clk); #1; lat++;
                if (lat == 2) c0_hi = add_c0;
            end
            sum = rsp_sum; cout = rsp_cout; ovf = rsp_ovf; rid = rsp_id;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 0; req0_valid = 1; #1;
        n_checks++; if (req0_ready !== 0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        n_checks++; if (busy !== 0 || rsp_valid !== 0) begin n_fail++; $display("FAIL reset_busy_valid: got %b%b want 00", busy, rsp_valid); end
        n_checks++; if (rsp_sum !== 0 || rsp_id !== 0 || rsp_cout !== 0 || rsp_ovf !== 0) begin n_fail++; $display("FAIL reset_rsp: got %h want 0", rsp_sum); end
        n_checks++; if (add_a !== 0 || add_b !== 0 || add_c0 !== 0) begin n_fail++; $display("FAIL reset_add: got %h %h %b want 0", add_a, add_b, add_c0); end
        @(posedge clk); #1; rst_n = 1; #1;
        n_checks++; if (req0_ready !== 1) begin n_fail++; $display("FAIL reset_release_ready0: got %b want 1", req0_ready); end
        req0_valid = 0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL reset_no_accept: busy got %b want 0", busy); end
    endtask

    task automatic test_single_add;
        logic [63:0] s; logic c, o, r, c0; int l;
        run_op(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, s, c, o, r, c0, l);
        n_checks++; if (l !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", l); end
        n_checks++; if (s !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL add_sum: got %h want 0000000100000000", s); end
        n_checks++; if ({c, o, r} !== 3'b000) begin n_fail++; $display("FAIL add_flags: cout/ovf/id got %b want 000", {c, o, r}); end
        n_checks++; if (c0 !== 1) begin n_fail++; $display("FAIL add_c0_hi: got %b want 1", c0); end
    endtask

    task automatic test_subtract;
        logic [63:0] s; logic c, o, r, c0; int l;
        run_op(1, 64'd5, 64'd7, 1, s, c, o, r, c0, l);
        n_checks++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_5_7_sum: got %h want fffffffffffffffe", s); end
        n_checks++; if ({c, o, r} !== 3'b001) begin n_fail++; $display("FAIL sub_5_7_flags: cout/ovf/id got %b want 001", {c, o, r}); end
        run_op(1, 64'd7, 64'd5, 1, s, c, o, r, c0, l);
        n_checks++; if (s !== 64'd2) begin n_fail++; $display("FAIL sub_7_5_sum: got %h want 2", s); end
        n_checks++; if ({c, o} !== 2'b10) begin n_fail++; $display("FAIL sub_7_5_flags: cout/ovf got %b want 10", {c, o}); end
    endtask

    task automatic test_boundary;
        logic [63:0] s; logic c, o, r, c0; int l;
        run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, s, c, o, r, c0, l);
        n_checks++; if (s !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL bnd_ovf_sum: got %h want 8000000000000000", s); end
        n_checks++; if ({c, o} !== 2'b01) begin n_fail++; $display("FAIL bnd_ovf_flags: cout/ovf got %b want 01", {c, o}); end
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, s, c, o, r, c0, l);
        n_checks++; if (s !== 64'd0) begin n_fail++; $display("FAIL bnd_wrap_sum: got %h want 0", s); end
        n_checks++; if ({c, o} !== 2'b10) begin n_fail++; $display("FAIL bnd_wrap_flags: cout/ovf got %b want 10", {c, o}); end
    endtask

    // Starts from reset so the pointer is back at RR_INIT=0.
    task automatic test_contention;
        rst_n = 0; #1; @(posedge clk); #1; rst_n = 1;
        rsp_ready = 1;
        req0_a = 64'd1;  req0_b = 64'd2; req0_sub = 0; req0_valid = 1;
        req1_a = 64'd10; req1_b = 64'd3; req1_sub = 1; req1_valid = 1;
        #1;
        for (int t = 0; t < 16; t++) begin
            n_checks++; if (req0_ready !== (t % 8 == 0) || req1_ready !== (t % 8 == 4)) begin
                n_fail++; $display("FAIL cont_ready t=%0d: got r0=%b r1=%b want r0=%b r1=%b", t, req0_ready, req1_ready, t % 8 == 0, t % 8 == 4);
            end
            if (t % 4 == 3) begin
                n_checks++; if (rsp_valid !== 1 || rsp_id !== ((t / 4) % 2 == 1) || rsp_sum !== (((t / 4) % 2 == 1) ? 64'd7 : 64'd3)) begin
                    n_fail++; $display("FAIL cont_rsp t=%0d: got v=%b id=%b sum=%h", t, rsp_valid, rsp_id, rsp_sum);
                end
            end
            if (t == 15) begin req0_valid = 0; req1_valid = 0; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        rsp_ready = 0;
        req0_a = 64'h1234; req0_b = 64'd1; req0_sub = 0; req0_valid = 1; #1;
        n_checks++; if (req0_ready !== 1) begin n_fail++; $display("FAIL bp_accept: ready0 got %b want 1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 0;
        req1_a = 64'd9; req1_b = 64'd1; req1_sub = 0; req1_valid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int t = 0; t < 5; t++) begin
            n_checks++; if (rsp_valid !== 1 || rsp_sum !== 64'h1235 || rsp_id !== 0 || busy !== 1) begin
                n_fail++; $display("FAIL bp_hold t=%0d: got v=%b sum=%h id=%b busy=%b want 1 1235 0 1", t, rsp_valid, rsp_sum, rsp_id, busy);
            end
            n_checks++; if (req0_ready !== 0 || req1_ready !== 0) begin n_fail++; $display("FAIL bp_readys t=%0d: got %b%b want 00", t, req0_ready, req1_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1; #1;
        n_checks++; if (req1_ready !== 0 || rsp_valid !== 1) begin n_fail++; $display("FAIL bp_handshake_cycle: ready1=%b valid=%b want 0 1", req1_ready, rsp_valid); end
        @(posedge clk); #1;
        n_checks++; if (req1_ready !== 1 || busy !== 0) begin n_fail++; $display("FAIL bp_next_accept: ready1=%b busy=%b want 1 0", req1_ready, busy); end
        @(posedge clk); #1;
        req1_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1 || rsp_id !== 1 || rsp_sum !== 64'd10) begin n_fail++; $display("FAIL bp_second_rsp: v=%b id=%b sum=%h want 1 1 a", rsp_valid, rsp_id, rsp_sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        logic [63:0] s; logic c, o, r, c0; int l;
        rsp_ready = 1;
        req0_a = 64'h5555; req0_b = 64'h1111; req0_sub = 0; req0_valid = 1; #1;
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        n_checks++; if (add_a !== 32'd0 || busy !== 1) begin n_fail++; $display("FAIL midop_in_hi: add_a=%h busy=%b want 0 1", add_a, busy); end
        req1_valid = 1; rst_n = 0; #1;
        n_checks++; if (busy !== 0 || rsp_valid !== 0 || add_c0 !== 0 || add_b !== 0) begin n_fail++; $display("FAIL midop_outputs: busy=%b v=%b c0=%b b=%h want 0", busy, rsp_valid, add_c0, add_b); end
        n_checks++; if (req1_ready !== 0 || rsp_sum !== 0) begin n_fail++; $display("FAIL midop_ready_sum: r1=%b sum=%h want 0 0", req1_ready, rsp_sum); end
        req1_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        for (int t = 0; t < 5; t++) begin
            n_checks++; if (rsp_valid !== 0) begin n_fail++; $display("FAIL midop_no_rsp t=%0d: got %b want 0", t, rsp_valid); end
            @(posedge clk); #1;
        end
        run_op(0, 64'd3, 64'd4, 0, s, c, o, r, c0, l);
        n_checks++; if (s !== 64'd7 || l !== 3 || r !== 0) begin n_fail++; $display("FAIL midop_after: sum=%h lat=%0d id=%b want 7 3 0", s, l, r); end
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_subtract;
        test_boundary;
        test_contention;
        test_backpressure;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
